// File: rtl/turret_pkg.sv
// Shared types and default constants for the turret command unit.
// The state encoding is exported to the HUD, so it is fixed at 2 bits.
package turret_pkg;

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_FIRE   = 2'd1,
    ST_COOL   = 2'd2,
    ST_RELOAD = 2'd3
  } turret_state_e;

  localparam int ANGLE_MAX_DEF   = 15;
  localparam int ANGLE_RESET_DEF = 8;
  localparam int AMMO_MAX_DEF    = 8;
  localparam int COOLDOWN_DEF    = 10;
  localparam int RELOAD_CYC_DEF  = 30;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter that stops at zero; shared by the cooldown and reload phases.
// A load takes priority over counting in the same cycle.
module frame_down_counter #(
  parameter int W = 5
) (
  input  logic         fclk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/turret_command_unit.sv
// Turns one-cycle button pulses into aim updates, ammo bookkeeping and
// valid/ready shot requests for the projectile engine. All outputs are registered.
module turret_command_unit
  import turret_pkg::*;
#(
  parameter int ANGLE_MAX   = ANGLE_MAX_DEF,
  parameter int ANGLE_RESET = ANGLE_RESET_DEF,
  parameter int AMMO_MAX    = AMMO_MAX_DEF,
  parameter int COOLDOWN    = COOLDOWN_DEF,
  parameter int RELOAD_CYC  = RELOAD_CYC_DEF
) (
  input  logic                             fclk,
  input  logic                             reset,
  input  logic                             btn_left,
  input  logic                             btn_right,
  input  logic                             btn_fire,
  input  logic                             btn_reload,
  input  logic                             shot_ready,
  output logic                             shot_valid,
  output logic [$clog2(ANGLE_MAX+1)-1:0]   shot_angle,
  output logic [$clog2(ANGLE_MAX+1)-1:0]   angle,
  output logic [$clog2(AMMO_MAX+1)-1:0]    ammo,
  output logic [1:0]                       state,
  output logic                             empty_click
);

  localparam int AW = $clog2(ANGLE_MAX + 1);
  localparam int MW = $clog2(AMMO_MAX + 1);
  localparam int TW = $clog2(imax(COOLDOWN, RELOAD_CYC) + 1);

  localparam logic [AW-1:0] ANGLE_TOP  = AW'(ANGLE_MAX);
  localparam logic [AW-1:0] ANGLE_INIT = AW'(ANGLE_RESET);
  localparam logic [MW-1:0] AMMO_FULL  = MW'(AMMO_MAX);
  localparam logic [TW-1:0] COOL_LOAD  = TW'(COOLDOWN);
  localparam logic [TW-1:0] RELD_LOAD  = TW'(RELOAD_CYC);

  turret_state_e   state_reg, state_next;
  logic [AW-1:0]   angle_reg, angle_next;
  logic [AW-1:0]   shot_angle_reg, shot_angle_next;
  logic [MW-1:0]   ammo_reg, ammo_next;
  logic            shot_valid_reg, shot_valid_next;
  logic            empty_click_reg, empty_click_next;

  logic            ctr_load;
  logic [TW-1:0]   ctr_value;
  logic            ctr_enable;
  logic [TW-1:0]   timer_count;
  logic            timer_zero;
  logic            timer_last;

  frame_down_counter #(
    .W (TW)
  ) u_timer (
    .fclk       (fclk),
    .reset      (reset),
    .load       (ctr_load),
    .load_value (ctr_value),
    .enable     (ctr_enable),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  // Leave the timed states together with the counter's final step so that
  // state and timer reach READY/0 in the same cycle.
  assign timer_last = timer_zero || (timer_count == TW'(1));

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_READY;
      angle_reg       <= ANGLE_INIT;
      shot_angle_reg  <= '0;
      ammo_reg        <= AMMO_FULL;
      shot_valid_reg  <= 1'b0;
      empty_click_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      angle_reg       <= angle_next;
      shot_angle_reg  <= shot_angle_next;
      ammo_reg        <= ammo_next;
      shot_valid_reg  <= shot_valid_next;
      empty_click_reg <= empty_click_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    angle_next       = angle_reg;
    shot_angle_next  = shot_angle_reg;
    ammo_next        = ammo_reg;
    shot_valid_next  = shot_valid_reg;
    empty_click_next = 1'b0;
    ctr_load         = 1'b0;
    ctr_value        = '0;
    ctr_enable       = (state_reg == ST_COOL) || (state_reg == ST_RELOAD);

    if (btn_left && !btn_right && (angle_reg != '0)) begin
      angle_next = angle_reg - AW'(1);
    end else if (btn_right && !btn_left && (angle_reg != ANGLE_TOP)) begin
      angle_next = angle_reg + AW'(1);
    end

    case (state_reg)
      ST_READY: begin
        if (btn_fire) begin
          if (ammo_reg != '0) begin
            shot_angle_next = angle_reg;
            shot_valid_next = 1'b1;
            state_next      = ST_FIRE;
          end else begin
            empty_click_next = 1'b1;
            if (btn_reload) begin
              ctr_load   = 1'b1;
              ctr_value  = RELD_LOAD;
              state_next = ST_RELOAD;
            end
          end
        end else if (btn_reload && (ammo_reg != AMMO_FULL)) begin
          ctr_load   = 1'b1;
          ctr_value  = RELD_LOAD;
          state_next = ST_RELOAD;
        end
      end

      ST_FIRE: begin
        if (shot_ready) begin
          shot_valid_next = 1'b0;
          ammo_next       = ammo_reg - MW'(1);
          if (COOLDOWN == 0) begin
            state_next = ST_READY;
          end else begin
            ctr_load   = 1'b1;
            ctr_value  = COOL_LOAD;
            state_next = ST_COOL;
          end
        end
      end

      ST_COOL: begin
        if (timer_last) begin
          state_next = ST_READY;
        end
      end

      ST_RELOAD: begin
        if (timer_last) begin
          ammo_next  = AMMO_FULL;
          state_next = ST_READY;
        end
      end

      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  assign state       = state_reg;
  assign angle       = angle_reg;
  assign shot_angle  = shot_angle_reg;
  assign ammo        = ammo_reg;
  assign shot_valid  = shot_valid_reg;
  assign empty_click = empty_click_reg;

endmodule

// File: tb/tb_turret_command_unit.sv
// Directed bench for turret_command_unit: aim saturation, fire/cooldown timing,
// handshake stalls, empty magazine, reload timing and mid-shot reset.
module tb_turret_command_unit;

  localparam logic [1:0] S_READY  = 2'd0;
  localparam logic [1:0] S_FIRE   = 2'd1;
  localparam logic [1:0] S_COOL   = 2'd2;
  localparam logic [1:0] S_RELOAD = 2'd3;

  logic       fclk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_fire = 1'b0;
  logic       btn_reload = 1'b0;
  logic       shot_ready = 1'b0;
  logic       shot_valid;
  logic [3:0] shot_angle;
  logic [3:0] angle;
  logic [3:0] ammo;
  logic [1:0] state;
  logic       empty_click;

  int n_checks = 0;
  int n_fail   = 0;

  turret_command_unit dut (
    .fclk        (fclk),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_fire    (btn_fire),
    .btn_reload  (btn_reload),
    .shot_ready  (shot_ready),
    .shot_valid  (shot_valid),
    .shot_angle  (shot_angle),
    .angle       (angle),
    .ammo        (ammo),
    .state       (state),
    .empty_click (empty_click)
  );

  always #5 fclk = ~fclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic press(input logic l, input logic r, input logic f, input logic rl);
    btn_left = l; btn_right = r; btn_fire = f; btn_reload = rl;
    tick();
    btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; btn_reload = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Fires one shot with shot_ready high and waits out the cooldown.
  task automatic fire_shot(input int exp_ammo_after);
    press(0, 0, 1, 0);
    check_val("shot_valid_set", shot_valid, 1);
    tick();
    check_val("ammo_after_shot", ammo, exp_ammo_after);
    repeat (10) tick();
    check_val("ready_after_cool", state, S_READY);
  endtask

  initial begin
    // Reset values
    repeat (2) tick();
    check_val("rst_state", state, S_READY);
    check_val("rst_angle", angle, 8);
    check_val("rst_ammo", ammo, 8);
    check_val("rst_shot_valid", shot_valid, 0);
    check_val("rst_shot_angle", shot_angle, 0);
    check_val("rst_empty_click", empty_click, 0);
    reset = 1'b0;

    // Reload while full is ignored
    press(0, 0, 0, 1);
    check_val("reload_full_ignored", state, S_READY);

    // Basic shot with ready held high, 10-cycle cooldown
    shot_ready = 1'b1;
    press(0, 0, 1, 0);
    check_val("t1_valid", shot_valid, 1);
    check_val("t1_state_fire", state, S_FIRE);
    check_val("t1_shot_angle", shot_angle, 8);
    check_val("t1_ammo_before", ammo, 8);
    tick();
    check_val("t1_valid_clear", shot_valid, 0);
    check_val("t1_ammo_after", ammo, 7);
    check_val("t1_state_cool", state, S_COOL);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_val("t1_still_cool", state, S_COOL);
    end
    tick();
    check_val("t1_back_ready", state, S_READY);

    // Stalled handshake with aim changes during FIRE
    shot_ready = 1'b0;
    press(0, 0, 1, 0);
    check_val("t2_valid", shot_valid, 1);
    press(0, 1, 0, 0);
    check_val("t2_angle_9", angle, 9);
    press(0, 1, 0, 0);
    check_val("t2_angle_10", angle, 10);
    press(1, 0, 0, 0);
    check_val("t2_angle_9b", angle, 9);
    press(0, 0, 1, 1);
    check_val("t2_fire_dropped", state, S_FIRE);
    tick();
    check_val("t2_valid_held", shot_valid, 1);
    check_val("t2_shot_angle_held", shot_angle, 8);
    check_val("t2_ammo_held", ammo, 7);
    shot_ready = 1'b1;
    tick();
    check_val("t2_valid_clear", shot_valid, 0);
    check_val("t2_ammo_after", ammo, 6);
    check_val("t2_shot_angle_kept", shot_angle, 8);
    repeat (10) tick();
    check_val("t2_ready", state, S_READY);

    // Aim saturation
    reset_dut();
    check_val("t3_angle_reset", angle, 8);
    repeat (10) press(0, 1, 0, 0);
    check_val("t3_sat_high", angle, 15);
    repeat (20) press(1, 0, 0, 0);
    check_val("t3_sat_low", angle, 0);
    press(1, 1, 0, 0);
    check_val("t3_both_at_0", angle, 0);
    press(0, 1, 0, 0);
    check_val("t3_right_1", angle, 1);
    press(1, 1, 0, 0);
    check_val("t3_both_at_1", angle, 1);

    // Empty the magazine, dry fire, then reload
    reset_dut();
    shot_ready = 1'b1;
    for (int i = 0; i < 8; i++) fire_shot(7 - i);
    press(0, 0, 1, 0);
    check_val("t4_empty_click", empty_click, 1);
    check_val("t4_no_valid", shot_valid, 0);
    check_val("t4_state_ready", state, S_READY);
    tick();
    check_val("t4_click_one_cycle", empty_click, 0);
    press(0, 0, 0, 1);
    check_val("t4_state_reload", state, S_RELOAD);
    for (int i = 0; i < 29; i++) begin
      if (i == 5) begin
        press(0, 0, 1, 0);
        check_val("t4_fire_in_reload_valid", shot_valid, 0);
        check_val("t4_fire_in_reload_click", empty_click, 0);
      end else begin
        tick();
      end
      check_val("t4_reloading", state, S_RELOAD);
    end
    check_val("t4_ammo_still_0", ammo, 0);
    tick();
    check_val("t4_reload_done_state", state, S_READY);
    check_val("t4_reload_done_ammo", ammo, 8);

    // Fire during COOL is dropped
    press(0, 0, 1, 0);
    tick();
    check_val("t5_cool", state, S_COOL);
    tick();
    tick();
    press(0, 0, 1, 0);
    repeat (7) tick();
    check_val("t5_ready", state, S_READY);
    check_val("t5_no_queued_shot", shot_valid, 0);
    tick();
    check_val("t5_no_queued_shot2", shot_valid, 0);
    check_val("t5_ammo", ammo, 7);
    for (int i = 0; i < 4; i++) fire_shot(6 - i);

    // Fire and reload together with ammo 3: fire wins
    press(0, 0, 1, 1);
    check_val("t5_fr_valid", shot_valid, 1);
    check_val("t5_fr_state", state, S_FIRE);
    tick();
    check_val("t5_fr_ammo", ammo, 2);
    check_val("t5_fr_cool", state, S_COOL);
    repeat (10) tick();
    check_val("t5_fr_ready", state, S_READY);
    check_val("t5_fr_ammo_kept", ammo, 2);

    // Reset while a shot is pending
    reset_dut();
    shot_ready = 1'b0;
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    check_val("t6_valid", shot_valid, 1);
    check_val("t6_shot_angle", shot_angle, 9);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_valid_dropped", shot_valid, 0);
    check_val("t6_ammo", ammo, 8);
    check_val("t6_angle", angle, 8);
    check_val("t6_state", state, S_READY);
    check_val("t6_shot_angle_rst", shot_angle, 0);
    tick();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
